// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the byte UART transmitter.
//            - uart_state_t    : frame sequencer states
//            - UART_DATA_BITS  : data bits per frame
//            - UART_IDLE_LEVEL : line level while idle / during stop bit
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_counter
// Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick is
//            high during the last count of each bit period, so the bit/state
//            advances on the edge where the counter wraps.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous active-high reset
//            clear - restart the period (counter to 0 on next edge)
//            tick  - high in the final cycle of the current bit period
// Params   : CLKS_PER_BIT - clocks per UART bit (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == C_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Not masked by clear: a stop bit ending in the same cycle as a new
  // transfer must still see its final tick.
  assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/byte_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : byte_uart_tx
// Purpose  : Serialises one byte per valid/ready handshake onto a UART line:
//            start (0), 8 data bits LSB first, optional even parity, stop (1).
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset (aborts any frame)
//            data_in    - byte to send, captured on handshake
//            data_valid - upstream byte available
//            data_ready - a byte can be accepted this cycle
//            tx         - serial line (flop output, idle high)
//            busy       - frame in progress, always ~data_ready
//            done       - single-cycle pulse in the final stop-bit cycle
// Params   : CLKS_PER_BIT - clocks per UART bit (>= 2)
// Config   : UART_TX_PARITY_EN - when defined, an even-parity bit follows
//            the data bits (11-bit frame); otherwise 10-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
module byte_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] C_LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic        r_tx;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  logic w_tick;
  logic w_last_stop;
  logic w_xfer;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_xfer),
    .tick  (w_tick)
  );

  // Ready is offered during the last stop-bit cycle so a byte held on the
  // input is taken on the very edge the stop bit ends: no idle gap between
  // back-to-back frames.
  assign w_last_stop = (r_state == STOP) && w_tick;
  assign data_ready  = (r_state == IDLE) || w_last_stop;
  assign busy        = ~data_ready;
  assign done        = w_last_stop;
  assign w_xfer      = data_valid && data_ready;
  assign tx          = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_state   <= START;
      r_shift   <= data_in;
      r_bit_idx <= '0;
      r_tx      <= ~UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_parity  <= ^data_in;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= UART_IDLE_LEVEL;
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= UART_IDLE_LEVEL;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_tx    <= UART_IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= UART_IDLE_LEVEL;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
